// File: rtl/alu_issue_stage_pkg.sv
// ============================================================================
// alu_issue_stage_pkg : ALU codes, RV32 opcodes, issue record and bubble value
// Revision 1.0
// ============================================================================
`default_nettype none

package alu_issue_stage_pkg;

  localparam int ISSUE_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_e;

  typedef struct packed {
    logic                  valid;
    logic                  illegal;
    alu_op_e               alu_ctrl;
    logic [ISSUE_XLEN-1:0] operand1;
    logic [ISSUE_XLEN-1:0] operand2;
    logic [ISSUE_XLEN-1:0] store_data;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } issue_t;

  localparam issue_t ISSUE_BUBBLE = '{
    valid:      1'b0,
    illegal:    1'b0,
    alu_ctrl:   ALU_ADD,
    operand1:   '0,
    operand2:   '0,
    store_data: '0,
    rd:         5'd0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0
  };

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
// alu_op_decode : combinational RV32I decode to ALU op, operand selects, imm
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_op_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_e     alu_ctrl,
  output op1_sel_e    op1_sel,
  output op2_sel_e    op2_sel,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};

  always_comb begin
    alu_ctrl  = ALU_ADD;
    op1_sel   = OP1_RS1;
    op2_sel   = OP2_IMM;
    imm       = '0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;

    case (opcode)
      OPC_OP: begin
        op2_sel   = OP2_RS2;
        reg_write = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: alu_ctrl = ALU_ADD;
          10'b0000000_001: alu_ctrl = ALU_SLL;
          10'b0000000_010: alu_ctrl = ALU_SLT;
          10'b0000000_011: alu_ctrl = ALU_SLTU;
          10'b0000000_100: alu_ctrl = ALU_XOR;
          10'b0000000_101: alu_ctrl = ALU_SRL;
          10'b0000000_110: alu_ctrl = ALU_OR;
          10'b0000000_111: alu_ctrl = ALU_AND;
          10'b0100000_000: alu_ctrl = ALU_SUB;
          10'b0100000_101: alu_ctrl = ALU_SRA;
          default:         illegal  = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        imm       = imm_i;
        reg_write = 1'b1;
        case (funct3)
          3'b000: alu_ctrl = ALU_ADD;
          3'b010: alu_ctrl = ALU_SLT;
          3'b011: alu_ctrl = ALU_SLTU;
          3'b100: alu_ctrl = ALU_XOR;
          3'b110: alu_ctrl = ALU_OR;
          3'b111: alu_ctrl = ALU_AND;
          3'b001: begin
            imm      = {27'b0, instr[24:20]};
            alu_ctrl = ALU_SLL;
            illegal  = (funct7 != 7'b0000000);
          end
          default: begin
            // funct3 101: funct7 picks SRLI vs SRAI
            imm = {27'b0, instr[24:20]};
            if (funct7 == 7'b0000000) begin
              alu_ctrl = ALU_SRL;
            end else if (funct7 == 7'b0100000) begin
              alu_ctrl = ALU_SRA;
            end else begin
              illegal = 1'b1;
            end
          end
        endcase
      end
      OPC_LUI: begin
        op1_sel   = OP1_ZERO;
        imm       = imm_u;
        alu_ctrl  = ALU_LUI;
        reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        op1_sel   = OP1_PC;
        imm       = imm_u;
        reg_write = 1'b1;
      end
      OPC_JAL: begin
        op1_sel   = OP1_PC;
        imm       = 32'd4;
        reg_write = 1'b1;
      end
      OPC_JALR: begin
        op1_sel   = OP1_PC;
        imm       = 32'd4;
        reg_write = 1'b1;
        illegal   = (funct3 != 3'b000);
      end
      OPC_LOAD: begin
        imm       = imm_i;
        mem_read  = 1'b1;
        reg_write = 1'b1;
      end
      OPC_STORE: begin
        imm       = imm_s;
        mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        op2_sel  = OP2_RS2;
        alu_ctrl = ALU_SUB;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      alu_ctrl  = ALU_ADD;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage : registered ID/EX issue stage with stall/flush/reset priority
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            stall,
  input  logic            flush,
  output logic            valid_out,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            illegal
);

  alu_op_e     dec_alu_ctrl;
  op1_sel_e    dec_op1_sel;
  op2_sel_e    dec_op2_sel;
  logic [31:0] dec_imm;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_illegal;

  issue_t load_val;
  issue_t issue_d;
  issue_t issue_q;

  alu_op_decode u_decode (
    .instr     (instr),
    .alu_ctrl  (dec_alu_ctrl),
    .op1_sel   (dec_op1_sel),
    .op2_sel   (dec_op2_sel),
    .imm       (dec_imm),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .illegal   (dec_illegal)
  );

  always_comb begin
    load_val = ISSUE_BUBBLE;
    if (valid_in) begin
      load_val.valid     = 1'b1;
      load_val.illegal   = dec_illegal;
      load_val.alu_ctrl  = dec_alu_ctrl;
      load_val.mem_read  = dec_mem_read;
      load_val.mem_write = dec_mem_write;
      load_val.rd        = dec_illegal ? 5'd0 : instr[11:7];
      // x0 is never written, whatever the opcode says
      load_val.reg_write = dec_reg_write && (instr[11:7] != 5'd0);
      if (!dec_illegal) begin
        case (dec_op1_sel)
          OP1_PC:   load_val.operand1 = pc;
          OP1_ZERO: load_val.operand1 = '0;
          default:  load_val.operand1 = rs1_data;
        endcase
        load_val.operand2   = (dec_op2_sel == OP2_RS2) ? rs2_data : dec_imm;
        load_val.store_data = dec_mem_write ? rs2_data : '0;
      end
    end
  end

  always_comb begin
    issue_d = load_val;
    if (flush) begin
      issue_d = ISSUE_BUBBLE;
    end else if (stall) begin
      issue_d = issue_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_q <= ISSUE_BUBBLE;
    end else begin
      issue_q <= issue_d;
    end
  end

  assign valid_out  = issue_q.valid;
  assign illegal    = issue_q.illegal;
  assign alu_ctrl   = issue_q.alu_ctrl;
  assign operand1   = issue_q.operand1;
  assign operand2   = issue_q.operand2;
  assign store_data = issue_q.store_data;
  assign rd         = issue_q.rd;
  assign reg_write  = issue_q.reg_write;
  assign mem_read   = issue_q.mem_read;
  assign mem_write  = issue_q.mem_write;

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered ID/EX issue stage for the RISC-V pipeline core. It takes one instruction and its register-file read data per cycle, decodes opcode/funct3/funct7 into the 4-bit ALU operation code, and selects the immediate and the two ALU operands. It drives the ALU inputs and destination-write controls one cycle later, with hazard-unit stall and flush.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `valid_in` in 1: ID stage holds a real instruction.
- `instr` in 32: instruction word.
- `pc` in 32: instruction address.
- `rs1_data` in 32: forwarded rs1 value.
- `rs2_data` in 32: forwarded rs2 value.
- `stall` in 1: hold all output registers.
- `flush` in 1: load a bubble.
- `valid_out` out 1: EX stage holds a real instruction.
- `alu_ctrl` out 4: ALU operation code.
- `operand1` out 32: ALU operand 1.
- `operand2` out 32: ALU operand 2.
- `store_data` out 32: rs2 value for stores.
- `rd` out 5: destination register.
- `reg_write` out 1: write rd at writeback. Forced to 0 when rd = 0.
- `mem_read` out 1: load.
- `mem_write` out 1: store.
- `illegal` out 1: unsupported encoding issued.

## Operation
- ALU codes: SLL=0, SRL=1, SRA=2, ADD=3, SUB=4, XOR=5, OR=6, AND=7, SLT=8, SLTU=9, LUI=10.
- OP (0110011): op1=rs1, op2=rs2.
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 SUB, 101 SRA.
  - Any other funct7/funct3 pair is illegal.
- OP-IMM (0010011): op1=rs1, op2=sign-extended I-imm.
  - funct3 mapping is the same as OP, with no SUB.
  - Shifts: op2 = {27'b0, instr[24:20]}.
  - SLLI/SRLI need instr[31:25]=0. SRAI needs 0100000. Otherwise illegal.
- LUI (0110111): op2={instr[31:12],12'b0}, alu_ctrl=LUI, op1=0.
- AUIPC (0010111): op1=pc, op2=U-imm, ADD.
- JAL (1101111) and JALR (1100111, funct3=000): op1=pc, op2=4, ADD, reg_write=1. Target computation is outside this block.
- LOAD (0000011): op1=rs1, op2=I-imm, ADD, mem_read=1, reg_write=1.
- STORE (0100011): op1=rs1, op2=S-imm, ADD, mem_write=1, store_data=rs2, reg_write=0.
- BRANCH (1100011): op1=rs1, op2=rs2, SUB, reg_write=0. Comparison happens in the branch unit.
- Any other opcode is illegal.
- Illegal issue: valid_out=1, illegal=1, reg_write=mem_read=mem_write=0, alu_ctrl=ADD, operands=0.
- Bubble: valid_out=0, alu_ctrl=ADD, operands/store_data/rd=0, all control bits 0.
- valid_in=0 loads a bubble.

## Timing
- Latency: 1 cycle from ID inputs to registered outputs. No combinational path from inputs to outputs.
- Reset (rst_n=0 at an edge): every output takes the bubble value, including valid_out=0 and alu_ctrl=3. Reset overrides stall and flush.
- Priority at each edge: reset > flush > stall > load.
- flush and stall both high: bubble is loaded.
- stall high: all outputs hold exactly, including across an arbitrarily long stall.
- Reset mid-stall: outputs go to bubble. After release, the first unstalled edge loads new input.
- Throughput: one instruction per cycle when stall=0.

## Structure
- Shared package/header: ALU code constants (extend the existing ALU code set, do not redefine values), opcode constants, and the bubble value.
- One combinational sub-module, `alu_op_decode`: instr → alu_ctrl, operand-select, immediate, control bits, illegal.
- The top level holds the registers and stall/flush/reset priority.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → next cycle: alu_ctrl=3, op1=5, op2=7, rd=3, reg_write=1, valid_out=1.
- SRAI x5,x6,4 (0x40435293), rs1=0xF0000000 → alu_ctrl=2, op2=4. Same with instr[30]=0 → alu_ctrl=1. With instr[31:25]=0100001 → illegal=1, reg_write=0.
- LUI x7,0x12345 (0x123453B7) → alu_ctrl=10, op2=0x12345000. AUIPC at pc=0x100 with imm 1 → op1=0x100, op2=0x1000, alu_ctrl=3.
- SW x2,-4(x1) (0xFE20AE23), rs1=0x200, rs2=0xAB → op2=0xFFFFFFFC, mem_write=1, store_data=0xAB, reg_write=0.
- Issue ADD, then assert stall for 3 cycles while changing inputs → outputs unchanged. Assert stall+flush → bubble next cycle.
- Pull rst_n low for one edge during a stall → all outputs bubble with alu_ctrl=3. Addi to x0 → reg_write=0. Opcode 0x7F → illegal=1.
